// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: mul/div op encoding,
// mul/div control states and iteration constants.
package mips_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_FIX  = 2'b10
   } muldiv_state_t;

   localparam int                MULDIV_ITER   = 32'd32;
   localparam int                MULDIV_CNT_W  = 32'd5;
   localparam logic [4:0]        MULDIV_LAST   = 5'd31;
   localparam logic [4:0]        MULDIV_CNT_INC = 5'd1;
   localparam logic [31:0]       DIV0_QUOTIENT = 32'hFFFFFFFF;

   function automatic logic isDivOp(input muldiv_op_t opCode);
      return (opCode == OP_DIVU) || (opCode == OP_DIV);
   endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// sign_fix: conditional two's-complement negation of a WIDTH-bit value.
// Used for operand magnitudes and result sign correction.
module sign_fix #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   // negate on request, pass through otherwise
   always_comb begin
      result = value;
      if (negate) begin
         result = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         result = value;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Signed ops are built only when SIGNED_MULDIV_EN is defined.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   muldiv_state_t state_r, nextState_s;

   logic [MULDIV_CNT_W-1:0] iterCnt_r;
   logic [2*WIDTH-1:0]      acc_r;
   logic [2*WIDTH-1:0]      accNext_s;
   logic [WIDTH-1:0]        operand_r;
   logic                    isDiv_r;
   logic                    divZero_r;
   logic                    isDivReq_s;

   logic loadOps_s, doStep_s, writeRes_s, moveHi_s, moveLo_s;

   logic [WIDTH-1:0]   magA_s, magB_s;
   logic [2*WIDTH-1:0] fixProd_s;
   logic [WIDTH-1:0]   fixQuo_s, fixRem_s;
   logic [WIDTH:0]     mulSum_s, divTrial_s;

   assign isDivReq_s = isDivOp(muldiv_op_t'(op));

`ifdef SIGNED_MULDIV_EN
   logic negA_s, negB_s;
   logic negQ_r, negR_r;

   assign negA_s = op[0] & a[WIDTH-1];
   assign negB_s = op[0] & b[WIDTH-1];

   sign_fix #(.WIDTH(WIDTH)) uAbsA (.value(a), .negate(negA_s), .result(magA_s));
   sign_fix #(.WIDTH(WIDTH)) uAbsB (.value(b), .negate(negB_s), .result(magB_s));
   sign_fix #(.WIDTH(2*WIDTH)) uFixProd (.value(acc_r), .negate(negQ_r), .result(fixProd_s));
   sign_fix #(.WIDTH(WIDTH)) uFixQuo (.value(acc_r[WIDTH-1:0]), .negate(negQ_r), .result(fixQuo_s));
   sign_fix #(.WIDTH(WIDTH)) uFixRem (.value(acc_r[2*WIDTH-1:WIDTH]), .negate(negR_r), .result(fixRem_s));

   // result signs: product/quotient negative on sign mismatch, remainder follows dividend
   always_ff @(posedge clk) begin
      if (rst) begin
         negQ_r <= 1'b0;
         negR_r <= 1'b0;
      end else if (loadOps_s) begin
         negQ_r <= negA_s ^ negB_s;
         negR_r <= negA_s;
      end
   end
`else
   assign magA_s    = a;
   assign magB_s    = b;
   assign fixProd_s = acc_r;
   assign fixQuo_s  = acc_r[WIDTH-1:0];
   assign fixRem_s  = acc_r[2*WIDTH-1:WIDTH];
`endif

   // acc holds {upper, lower}: product accumulates in upper, remainder/quotient for divide
   assign mulSum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, operand_r};
   assign divTrial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, operand_r};

   // one shift-add or restoring shift-subtract step
   always_comb begin
      accNext_s = acc_r;
      if (isDiv_r) begin
         if (!divTrial_s[WIDTH]) begin
            accNext_s = {divTrial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
         end else begin
            accNext_s = {acc_r[2*WIDTH-2:0], 1'b0};
         end
      end else begin
         if (acc_r[0]) begin
            accNext_s = {mulSum_s, acc_r[WIDTH-1:1]};
         end else begin
            accNext_s = {1'b0, acc_r[2*WIDTH-1:1]};
         end
      end
   end

   // control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= MD_IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // next-state decode
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         MD_IDLE: begin
            if (start) begin
               nextState_s = MD_RUN;
            end else begin
               nextState_s = MD_IDLE;
            end
         end
         MD_RUN: begin
            if (iterCnt_r == MULDIV_LAST) begin
               nextState_s = MD_FIX;
            end else begin
               nextState_s = MD_RUN;
            end
         end
         MD_FIX:  nextState_s = MD_IDLE;
         default: nextState_s = MD_IDLE;
      endcase
   end

   // per-state control strobes; a start in IDLE wins over a register move
   always_comb begin
      loadOps_s  = 1'b0;
      doStep_s   = 1'b0;
      writeRes_s = 1'b0;
      moveHi_s   = 1'b0;
      moveLo_s   = 1'b0;
      case (state_r)
         MD_IDLE: begin
            loadOps_s = start;
            moveHi_s  = mthi & ~start;
            moveLo_s  = mtlo & ~start;
         end
         MD_RUN:  doStep_s   = 1'b1;
         MD_FIX:  writeRes_s = 1'b1;
         default: begin
            loadOps_s  = 1'b0;
            doStep_s   = 1'b0;
         end
      endcase
   end

   // operand latch and iteration datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         iterCnt_r <= {MULDIV_CNT_W{1'b0}};
         acc_r     <= {(2*WIDTH){1'b0}};
         operand_r <= {WIDTH{1'b0}};
         isDiv_r   <= 1'b0;
         divZero_r <= 1'b0;
      end else if (loadOps_s) begin
         iterCnt_r <= {MULDIV_CNT_W{1'b0}};
         isDiv_r   <= isDivReq_s;
         divZero_r <= (b == {WIDTH{1'b0}});
         if (isDivReq_s) begin
            acc_r     <= {{WIDTH{1'b0}}, magA_s};
            operand_r <= magB_s;
         end else begin
            acc_r     <= {{WIDTH{1'b0}}, magB_s};
            operand_r <= magA_s;
         end
      end else if (doStep_s) begin
         acc_r     <= accNext_s;
         iterCnt_r <= iterCnt_r + MULDIV_CNT_INC;
      end
   end

   // architectural HI/LO and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         hi   <= {WIDTH{1'b0}};
         lo   <= {WIDTH{1'b0}};
      end else begin
         busy <= (nextState_s != MD_IDLE);
         done <= writeRes_s;
         if (writeRes_s) begin
            if (isDiv_r) begin
               hi <= fixRem_s;
               lo <= divZero_r ? WIDTH'(DIV0_QUOTIENT) : fixQuo_s;
            end else begin
               hi <= fixProd_s[2*WIDTH-1:WIDTH];
               lo <= fixProd_s[WIDTH-1:0];
            end
         end else begin
            if (moveHi_s) hi <= a;
            if (moveLo_s) lo <= a;
         end
      end
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS datapath. Sits directly downstream of the register file: it consumes the two read ports (rs on `a`, rt on `b`) and executes MULT/MULTU/DIV/DIVU over a fixed number of cycles. It also holds HI/LO for MFHI/MFLO/MTHI/MTLO. The control FSM stalls on `busy` and resumes on `done`.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  start request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  rs operand (register file `readData1`).
- `b`  in  WIDTH  rt operand (register file `readData2`).
- `mthi`  in  1  write `a` into HI.
- `mtlo`  in  1  write `a` into LO.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO hold a new result.
- `hi`  out  WIDTH  HI register; feeds MFHI.
- `lo`  out  WIDTH  LO register; feeds MFLO.

## Operation
- **FSM states:** IDLE, RUN, FIX.
  - IDLE → RUN on `start`. On the same edge: latch `op`, latch `a`/`b` as magnitudes (absolute values for signed ops), record the result signs, and clear the 5-bit iteration counter.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Stays in RUN for exactly 32 cycles, counter 0..31. Leaves RUN when the counter is 31.
  - FIX: apply sign correction and write HI/LO. Go to IDLE. `done` is registered high for the next cycle.
- **Multiply result:** 64-bit product. HI = bits [63:32], LO = bits [31:0]. For signed ops, negate the 64-bit product when the operand signs differ.
- **Divide result:** LO = quotient, HI = remainder. For signed ops, the quotient is negated when the signs differ, and the remainder takes the sign of the dividend (truncating division).
- **Divide by zero:** no trap. Latency is unchanged. Result is HI = `a`, LO = 0xFFFFFFFF, for both DIV and DIVU.
- **Signed overflow:** DIV of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **Ignored inputs:** `start`, `mthi` and `mtlo` are ignored while `busy` is high.
- **`mthi`/`mtlo` in IDLE:** update HI/LO on the next edge.
- **`start` together with `mthi`/`mtlo` in IDLE:** `start` wins and the move is dropped.
- HI/LO hold their values between operations. HI/LO are not modified in RUN; the old values stay visible until FIX.

## Timing
- **Reset:** `rst` high at any edge, including mid-RUN, forces IDLE. `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0. The in-flight operation is discarded.
- **Latency:** `start` sampled at edge E0. `busy` is high from E0+1 through E0+33 (32 RUN cycles plus FIX). HI/LO are updated at edge E0+33. `done` is high for exactly one cycle after E0+33, with `busy` low in that cycle.
- **Back-to-back:** a `start` in the `done` cycle is accepted, because the FSM is already in IDLE.
- `busy` and `done` are never high together.
- `hi`/`lo` are direct register outputs, with no combinational path from the inputs.

## Configuration
- `SIGNED_MULDIV_EN` defined: MULT and DIV are supported, with operand absolute value, sign recording and the FIX-stage negation.
- `SIGNED_MULDIV_EN` undefined: `op[0]` is ignored. MULT executes as MULTU and DIV as DIVU. The sign logic is removed. The FIX state still exists, so latency is identical.

## Structure
- **Shared package `mips_pkg`:**
  - `muldiv_op_t`, the 2-bit op encoding.
  - The muldiv state enum: IDLE, RUN, FIX.
  - `MULDIV_ITER` = 32.
  - `DIV0_QUOTIENT` = 32'hFFFFFFFF.
- **Sub-module `sign_fix`:** conditional two's-complement negation of a 64-bit value, also used on the 32-bit operands and the quotient/remainder. It is instantiated only under `SIGNED_MULDIV_EN`.

## Test plan
- **MULTU:** `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → `done` 34 cycles after `start`; HI=0xFFFFFFFE, LO=0x00000001.
- **MULT:** `a`=0xFFFFFFFD (-3), `b`=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **DIVU:** 100/7 → LO=14, HI=2.
  - DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** DIVU `a`=0x1234, `b`=0 → HI=0x00001234, LO=0xFFFFFFFF, with the same 34-cycle latency.
- **Ignored while busy:** `start` (with new operands) and `mthi` pulsed during RUN → both ignored; the result matches the first operation only.
  - `mtlo` `a`=0xCAFEF00D in IDLE → LO=0xCAFEF00D on the next cycle.
- **Reset mid-operation:** `rst` high 10 cycles into RUN → next cycle `busy`=0, `done`=0, HI=LO=0.
  - A fresh `start` after reset completes with the correct result.
